// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and defaults for the SR latch command generator.
// Optional shadow tracking is enabled with SR_CMD_SHADOW_EN.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_e;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int PULSE_CYCLES_DEF    = 2;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and latch drive outputs of sr_cmd_gen.
// q_shadow exists only when SR_CMD_SHADOW_EN is defined.
interface sr_cmd_gen_if;
  logic set_btn;
  logic clr_btn;
  logic s_out;
  logic r_out;
  logic en_out;
  logic busy;
`ifdef SR_CMD_SHADOW_EN
  logic q_shadow;

  modport master (
    output set_btn, clr_btn,
    input  s_out, r_out, en_out, busy, q_shadow
  );
  modport slave (
    input  set_btn, clr_btn,
    output s_out, r_out, en_out, busy, q_shadow
  );
`else
  modport master (
    output set_btn, clr_btn,
    input  s_out, r_out, en_out, busy
  );
  modport slave (
    input  set_btn, clr_btn,
    output s_out, r_out, en_out, busy
  );
`endif
endinterface

// File: rtl/sr_cmd_gen_btn_debounce.sv
// Two-flop synchroniser, stability counter and registered
// rising-edge pulse for one raw push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         sync1_q, sync2_q;
  logic         level_q, level_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         rise_q, rise_d;

  // Count consecutive disagreeing samples; flip level on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Synchroniser, debounced level, counter and edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear presses into exclusive S/R/enable
// pulses. Define SR_CMD_SHADOW_EN to add q_shadow tracking.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst_n,
  sr_cmd_gen_if.slave bus
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);

  logic          set_rise, clr_rise;
  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          set_pend_q, set_pend_d;
  logic          clr_pend_q, clr_pend_d;
  logic          s_q, s_d, r_q, r_d, en_q, en_d;
  logic          set_take, clr_take;
  logic          any_pend, drop;
  cmd_e          pick;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (bus.set_btn),
    .rise_o(set_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (bus.clr_btn),
    .rise_o(clr_rise)
  );

  assign any_pend = set_pend_q | clr_pend_q;
  assign pick     = clr_pend_q ? CMD_CLR : CMD_SET;

`ifdef SR_CMD_SHADOW_EN
  logic q_shadow_q;

  assign drop = ((pick == CMD_SET) == q_shadow_q);

  // Expected latch Q, committed as each pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_shadow_q <= 1'b0;
    end else if (state_q == DRIVE && pcnt_q == PLAST) begin
      q_shadow_q <= (cmd_q == CMD_SET);
    end
  end

  assign bus.q_shadow = q_shadow_q;
`else
  assign drop = 1'b0;
`endif

  // Next state and registered outputs; GAP may launch directly.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pcnt_d   = pcnt_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    en_d     = 1'b0;
    set_take = 1'b0;
    clr_take = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (any_pend) begin
          clr_take = (pick == CMD_CLR);
          set_take = (pick == CMD_SET);
          if (!drop) begin
            state_d = DRIVE;
            cmd_d   = pick;
            pcnt_d  = '0;
            s_d     = (pick == CMD_SET);
            r_d     = (pick == CMD_CLR);
            en_d    = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (pcnt_q == PLAST) begin
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
          s_d    = (cmd_q == CMD_SET);
          r_d    = (cmd_q == CMD_CLR);
          en_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // New edges always latch; a consumed flag clears.
  always_comb begin
    set_pend_d = (set_pend_q & ~set_take) | set_rise;
    clr_pend_d = (clr_pend_q & ~clr_take) | clr_rise;
  end

  // State, pending flags and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_SET;
      pcnt_q     <= '0;
      set_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      pcnt_q     <= pcnt_d;
      set_pend_q <= set_pend_d;
      clr_pend_q <= clr_pend_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
    end
  end

  assign bus.s_out  = s_q;
  assign bus.r_out  = r_q;
  assign bus.en_out = en_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Upstream command stage for the enabled SR latch. It takes two raw asynchronous push-button requests, set_btn and clr_btn, and synchronises and debounces each one. It then issues clean, mutually exclusive S/R/enable command pulses, so the latch never sees S=R=1 and never sees a request that arrives without an enable.

Parameters:
DEBOUNCE_CYCLES, 8, consecutive stable synchronised samples required before a button level is accepted (>=1)
PULSE_CYCLES, 2, cycles that S or R and enable are held high per command (>=1)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
set_btn  input  1  raw asynchronous set request, active high
clr_btn  input  1  raw asynchronous clear request, active high
s_out  output  1  S drive to latch
r_out  output  1  R drive to latch
en_out  output  1  latch enable
busy  output  1  high while in DRIVE or GAP

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: s_out=0, r_out=0, en_out=0, busy=0; sync flops, debounced levels, debounce counters and pending flags all cleared; FSM=IDLE. Assertion mid-pulse drops all outputs immediately, without waiting for a clock edge.
- Sync: each button passes through 2 flops.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever the synced sample equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the debounced level flips and the counter clears.
- Edge detect: a rising edge on a debounced level sets that channel's pending flag (set_pend or clr_pend). Falling edges are ignored.
- FSM IDLE -> DRIVE:
  - Taken when any pending flag is set.
  - Chooses CLR if clr_pend, else SET; clear wins on a tie. The chosen flag is cleared.
  - Outputs are registered: s_out/r_out and en_out rise in the first DRIVE cycle.
- DRIVE:
  - en_out=1; exactly one of s_out/r_out=1, held for PULSE_CYCLES cycles.
  - Then -> GAP.
- GAP:
  - All outputs 0 for exactly 1 cycle, then -> IDLE.
  - The next pending command therefore starts no sooner than PULSE_CYCLES+1 cycles after the previous one started.
- Pending during busy: edges are captured into the flags. Repeated edges on the same channel merge into one command.
- Invariant: s_out & r_out is never 1; s_out|r_out implies en_out.
- Latency: raw edge to en_out high = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge/pending) + 1 (FSM register) cycles, when IDLE.

Optional Feature:
- Macro: SR_CMD_SHADOW_EN.
- Defined:
  - Adds output q_shadow (1 bit, reset 0), tracking the expected latch Q: set to 1 after a SET DRIVE and to 0 after a CLR DRIVE, updated on DRIVE->GAP.
  - A pending command that matches q_shadow is dropped in IDLE without driving; the FSM stays IDLE.
- Undefined: no q_shadow port; every pending command is issued.

Decomposition:
- Package sr_cmd_pkg:
  - FSM state enum (IDLE, DRIVE, GAP) as 2-bit typedef
  - cmd typedef (CMD_SET, CMD_CLR)
  - default constant values for both parameters
- Sub-module btn_debounce: 2-flop sync + counter + rising-edge pulse output. Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2):
- Clean set: set_btn 0->1 held 20 cycles -> en_out=s_out=1 for exactly 2 cycles, starting 8 cycles after the edge; r_out stays 0; busy high 3 cycles.
- Bounce rejection: set_btn toggles every 2 cycles for 12 cycles, then settles at 1 -> exactly one SET pulse, beginning 8 cycles after the final rise.
- Simultaneous press: set_btn and clr_btn rise on the same edge -> CLR pulse (2 cycles), 1 gap cycle, then SET pulse (2 cycles); s_out&r_out never 1.
- Press during busy: clr press debounced while a SET is in DRIVE -> CLR issued immediately after GAP. A second set press during the same window yields one extra SET only.
- Reset mid-operation: rst_n low during DRIVE cycle 1 -> s_out/en_out 0 within the same cycle, with no clock edge needed. After release, no residual command issues without a new press.
- SR_CMD_SHADOW_EN: SET, then SET again -> second press issues nothing, q_shadow=1. A following CLR -> r_out pulse and q_shadow=0 after DRIVE.
